// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and the
// counter width helper.
`default_nettype none

package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Bits needed to count 0..n inclusive.
  function automatic int cw_for(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_sub_full_sub1.sv
// Gate-level 1-bit full subtractor: D = A ^ B ^ B_in, with the borrow
// raised when A < B + B_in.
`default_nettype none

module full_sub1 (
  input  wire A,
  input  wire B,
  input  wire B_in,
  output wire D,
  output wire B_out
);

  wire a_n;
  wire x_ab;
  wire t_ab;
  wire t_ac;
  wire t_bc;

  not g_inv  (a_n, A);
  xor g_xor0 (x_ab, A, B);
  xor g_xor1 (D, x_ab, B_in);
  and g_and0 (t_ab, a_n, B);
  and g_and1 (t_ac, a_n, B_in);
  and g_and2 (t_bc, B, B_in);
  or  g_or0  (B_out, t_ab, t_ac, t_bc);

endmodule

`default_nettype wire

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor D = A - B - B_in, LSB first, one bit per clock,
// with a serial output stream and a parallel result plus borrow-out.
`default_nettype none

module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = cw_for(N)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         B_in,
  output logic         busy,
  output logic         Q_ser,
  output logic         Q_valid,
  output logic         done,
  output logic [N-1:0] D,
  output logic         B_out
);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_sr_q,  a_sr_d;
  logic [N-1:0]  b_sr_q,  b_sr_d;
  logic          br_q,    br_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [N-1:0]  res_q,   res_d;
  logic [N-1:0]  dout_q,  dout_d;
  logic          bout_q,  bout_d;

  wire           bit_d;
  wire           bit_nbr;
  logic [N-1:0]  res_shift;

  full_sub1 u_fs (
    .A     (a_sr_q[0]),
    .B     (b_sr_q[0]),
    .B_in  (br_q),
    .D     (bit_d),
    .B_out (bit_nbr)
  );

  assign res_shift = {bit_d, res_q[N-1:1]};

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dout_d  = dout_q;
    bout_d  = bout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = A;
          b_sr_d  = B;
          br_d    = B_in;
          cnt_d   = '0;
          res_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        res_d  = res_shift;
        br_d   = bit_nbr;
        cnt_d  = cnt_q + CW'(1);
        // Capture the parallel result on the final bit so it is valid in DONE.
        if (cnt_q == CW'(N - 1)) begin
          dout_d  = res_shift;
          bout_d  = bit_nbr;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      dout_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dout_q  <= dout_d;
      bout_q  <= bout_d;
    end
  end

  assign busy    = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign Q_valid = (state_q == ST_RUN);
  assign Q_ser   = (state_q == ST_RUN) ? bit_d : 1'b0;
  assign done    = (state_q == ST_DONE);
  assign D       = dout_q;
  assign B_out   = bout_q;

endmodule

`default_nettype wire
